// File: rtl/goalpost_pkg.sv
// goalpost_ctrl_core shared definitions:
// register indices, status bit positions, serializer states.
package goalpost_pkg;

  localparam logic [4:0] REG_BMP_DATA = 5'd0;
  localparam logic [4:0] REG_BMP_ADDR = 5'd1;
  localparam logic [4:0] REG_POS      = 5'd2;
  localparam logic [4:0] REG_CTRL     = 5'd3;
  localparam logic [4:0] REG_STATUS   = 5'd4;

  localparam int PIX_PER_WORD = 16;

  localparam int STS_BUSY    = 0;
  localparam int STS_OVF     = 1;
  localparam int STS_PEND    = 2;
  localparam int STS_PTR_LSB = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

endpackage

// File: rtl/goalpost_ctrl_core_if.sv
// MMIO slot bus between the slot decoder
// (master) and goalpost_ctrl_core (slave).
interface goalpost_ctrl_core_if;

  logic        cs;
  logic        write;
  logic        read;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs,
    output write,
    output read,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  cs,
    input  write,
    input  read,
    input  addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/goalpost_ctrl_core_bmp_serializer.sv
// Unpacks a 32-bit bitmap word into 16 pixel
// writes on the RAM port, one per cycle.
module bmp_serializer
  import goalpost_pkg::*;
#(
  parameter int ADDR     = 10,
  parameter int PIX_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_data_wr,
  input  logic                i_addr_wr,
  input  logic                i_ovf_clr,
  input  logic [31:0]         i_data,
  output logic                o_we,
  output logic [ADDR-1:0]     o_addr_w,
  output logic [PIX_BITS-1:0] o_pix,
  output logic                o_busy,
  output logic                o_ovf,
  output logic [ADDR-1:0]     o_ptr
);

  // Pixel 0 leaves on the accept edge, so
  // SHIFT emits pixels 1..15 (cnt 0..14).
  localparam logic [3:0] LAST =
    4'(PIX_PER_WORD - 2);

  ser_state_t          r_state;
  logic [31:0]         r_word;
  logic [3:0]          r_cnt;
  logic [ADDR-1:0]     r_ptr;
  logic                r_we;
  logic [ADDR-1:0]     r_addr_w;
  logic [PIX_BITS-1:0] r_pix;
  logic                r_ovf;

  // Serializer FSM, pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_word   <= '0;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_we     <= 1'b0;
      r_addr_w <= '0;
      r_pix    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_ovf_clr)
        r_ovf <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_we <= 1'b0;
          if (i_data_wr) begin
            r_we     <= 1'b1;
            r_addr_w <= r_ptr;
            r_pix    <= i_data[PIX_BITS-1:0];
            r_word   <= i_data >> PIX_BITS;
            r_ptr    <= r_ptr + 1'b1;
            r_cnt    <= '0;
            r_state  <= SHIFT;
          end else if (i_addr_wr) begin
            r_ptr <= i_data[ADDR-1:0];
          end
        end
        SHIFT: begin
          r_we     <= 1'b1;
          r_addr_w <= r_ptr;
          r_pix    <= r_word[PIX_BITS-1:0];
          r_word   <= r_word >> PIX_BITS;
          r_ptr    <= r_ptr + 1'b1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST)
            r_state <= IDLE;
          if (i_data_wr | i_addr_wr)
            r_ovf <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_we     = r_we;
  assign o_addr_w = r_addr_w;
  assign o_pix    = r_pix;
  assign o_busy   = (r_state == SHIFT);
  assign o_ovf    = r_ovf;
  assign o_ptr    = r_ptr;

endmodule

// File: rtl/goalpost_ctrl_core.sv
// Goalpost register slot: position double
// buffer, enable mux and bitmap loader.
module goalpost_ctrl_core
  import goalpost_pkg::*;
#(
  parameter int          ADDR     = 10,
  parameter int          PIX_BITS = 2,
  parameter int          X_INIT   = 0,
  parameter int          Y_INIT   = 400,
  parameter logic [10:0] OFF_X    = 11'h7FF
) (
  input  logic                clk,
  input  logic                rst_n,
  goalpost_ctrl_core_if.slave bus,
  input  logic                frame_start,
  output logic [10:0]         x0,
  output logic [10:0]         y0,
  output logic                we,
  output logic [ADDR-1:0]     addr_w,
  output logic [PIX_BITS-1:0] pixel_in
);

  logic            w_wr;
  logic            w_data_wr;
  logic            w_addr_wr;
  logic            w_pos_wr;
  logic            w_ctrl_wr;
  logic            w_sts_wr;
  logic            w_busy;
  logic            w_ovf;
  logic [ADDR-1:0] w_ptr;
  logic [10:0]     w_wx;
  logic [10:0]     w_wy;

  logic [10:0] r_sh_x;
  logic [10:0] r_sh_y;
  logic [10:0] r_act_x;
  logic [10:0] r_act_y;
  logic        r_pend;
  logic        r_en;
  logic [10:0] r_x0;

  logic [10:0] w_sh_x_n;
  logic [10:0] w_sh_y_n;
  logic [10:0] w_act_x_n;
  logic [10:0] w_act_y_n;
  logic        w_pend_n;
  logic        w_en_n;

  logic [31:0] w_sts;
  logic [31:0] w_rd;

  assign w_wr = bus.cs & bus.write;
  assign w_data_wr =
    w_wr && (bus.addr == REG_BMP_DATA);
  assign w_addr_wr =
    w_wr && (bus.addr == REG_BMP_ADDR);
  assign w_pos_wr =
    w_wr && (bus.addr == REG_POS);
  assign w_ctrl_wr =
    w_wr && (bus.addr == REG_CTRL);
  assign w_sts_wr =
    w_wr && (bus.addr == REG_STATUS);

  assign w_wx = bus.wr_data[10:0];
  assign w_wy = bus.wr_data[26:16];

  bmp_serializer #(
    .ADDR     (ADDR),
    .PIX_BITS (PIX_BITS)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data_wr (w_data_wr),
    .i_addr_wr (w_addr_wr),
    .i_ovf_clr (w_sts_wr),
    .i_data    (bus.wr_data),
    .o_we      (we),
    .o_addr_w  (addr_w),
    .o_pix     (pixel_in),
    .o_busy    (w_busy),
    .o_ovf     (w_ovf),
    .o_ptr     (w_ptr)
  );

  // Next shadow/active position, pending and enable.
  always_comb begin
    w_sh_x_n  = r_sh_x;
    w_sh_y_n  = r_sh_y;
    w_act_x_n = r_act_x;
    w_act_y_n = r_act_y;
    w_pend_n  = r_pend;
    w_en_n    = r_en;
    if (w_pos_wr) begin
      w_sh_x_n = w_wx;
      w_sh_y_n = w_wy;
      if (frame_start) begin
        w_act_x_n = w_wx;
        w_act_y_n = w_wy;
        w_pend_n  = 1'b0;
      end else begin
        w_pend_n = 1'b1;
      end
    end else if (frame_start && r_pend) begin
      w_act_x_n = r_sh_x;
      w_act_y_n = r_sh_y;
      w_pend_n  = 1'b0;
    end
    if (w_ctrl_wr)
      w_en_n = bus.wr_data[0];
  end

  // Position registers; x0 is muxed off-screen
  // from the next enable so re-enable is prompt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_x  <= 11'(X_INIT);
      r_sh_y  <= 11'(Y_INIT);
      r_act_x <= 11'(X_INIT);
      r_act_y <= 11'(Y_INIT);
      r_pend  <= 1'b0;
      r_en    <= 1'b1;
      r_x0    <= 11'(X_INIT);
    end else begin
      r_sh_x  <= w_sh_x_n;
      r_sh_y  <= w_sh_y_n;
      r_act_x <= w_act_x_n;
      r_act_y <= w_act_y_n;
      r_pend  <= w_pend_n;
      r_en    <= w_en_n;
      r_x0    <= w_en_n ? w_act_x_n : OFF_X;
    end
  end

  assign x0 = r_x0;
  assign y0 = r_act_y;

  // Read-back mux; reads have no side effects.
  always_comb begin
    w_sts = '0;
    w_sts[STS_BUSY] = w_busy;
    w_sts[STS_OVF]  = w_ovf;
    w_sts[STS_PEND] = r_pend;
    w_sts[STS_PTR_LSB +: ADDR] = w_ptr;
    w_rd = '0;
    if (bus.cs & bus.read) begin
      unique case (bus.addr)
        REG_POS:
          w_rd = {5'd0, r_sh_y, 5'd0, r_sh_x};
        REG_CTRL:   w_rd = {31'd0, r_en};
        REG_STATUS: w_rd = w_sts;
        default:    w_rd = '0;
      endcase
    end
  end

  assign bus.rd_data = w_rd;

endmodule

// File: tb/tb_goalpost_ctrl_core.sv
// Directed self-checking bench for
// goalpost_ctrl_core.
module tb_goalpost_ctrl_core;
  import goalpost_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [10:0] x0;
  logic [10:0] y0;
  logic        we;
  logic [9:0]  addr_w;
  logic [1:0]  pixel_in;

  int passed;
  int total;

  goalpost_ctrl_core_if u_bus ();

  goalpost_ctrl_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (u_bus),
    .frame_start (frame_start),
    .x0          (x0),
    .y0          (y0),
    .we          (we),
    .addr_w      (addr_w),
    .pixel_in    (pixel_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    u_bus.cs      = 1'b1;
    u_bus.write   = 1'b1;
    u_bus.addr    = a;
    u_bus.wr_data = d;
    @(posedge clk);
    #1;
    u_bus.cs    = 1'b0;
    u_bus.write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a,
                    output logic [31:0] d);
    @(negedge clk);
    u_bus.cs   = 1'b1;
    u_bus.read = 1'b1;
    u_bus.addr = a;
    #1;
    d = u_bus.rd_data;
    u_bus.cs   = 1'b0;
    u_bus.read = 1'b0;
  endtask

  task automatic fs_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    total++;
    if (x0 !== 11'd0)
      $display("FAIL reset_x0: got %0d want 0", x0);
    else passed++;
    total++;
    if (y0 !== 11'd400)
      $display("FAIL reset_y0: got %0d want 400", y0);
    else passed++;
    total++;
    if (we !== 1'b0)
      $display("FAIL reset_we: got %b want 0", we);
    else passed++;
    rd(REG_STATUS, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL reset_status: got %h want 0", d);
    else passed++;
  endtask

  task automatic test_load();
    logic [31:0] d;
    wr(REG_BMP_ADDR, 32'd0);
    wr(REG_BMP_DATA, 32'hE4E4_E4E4);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (we !== 1'b1 || addr_w !== 10'(i) ||
          pixel_in !== 2'(i % 4))
        $display("FAIL load_px%0d: got we=%b a=%0d p=%0d want 1 %0d %0d",
                 i, we, addr_w, pixel_in, i, i % 4);
      else passed++;
      if (i == 3) begin
        u_bus.cs   = 1'b1;
        u_bus.read = 1'b1;
        u_bus.addr = REG_STATUS;
        #1;
        total++;
        if (u_bus.rd_data[0] !== 1'b1)
          $display("FAIL load_busy: got %b want 1",
                   u_bus.rd_data[0]);
        else passed++;
        u_bus.cs   = 1'b0;
        u_bus.read = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (we !== 1'b0)
      $display("FAIL load_we_end: got %b want 0", we);
    else passed++;
    rd(REG_STATUS, d);
    total++;
    if (d !== 32'h0010_0000)
      $display("FAIL load_status: got %h want 00100000", d);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int ea;
    wr(REG_BMP_ADDR, 32'd1020);
    wr(REG_BMP_DATA, 32'h5555_5555);
    for (int i = 0; i < 16; i++) begin
      ea = (1020 + i) % 1024;
      total++;
      if (we !== 1'b1 || addr_w !== 10'(ea) ||
          pixel_in !== 2'd1)
        $display("FAIL wrap_px%0d: got we=%b a=%0d p=%0d want 1 %0d 1",
                 i, we, addr_w, pixel_in, ea);
      else passed++;
      @(posedge clk);
      #1;
    end
    rd(REG_STATUS, d);
    total++;
    if (d !== 32'h000C_0000)
      $display("FAIL wrap_status: got %h want 000c0000", d);
    else passed++;
  endtask

  task automatic test_ovf();
    logic [31:0] d;
    int nwe;
    int psum;
    nwe  = 0;
    psum = 0;
    wr(REG_BMP_ADDR, 32'd100);
    wr(REG_BMP_DATA, 32'h0000_0000);
    for (int i = 0; i < 20; i++) begin
      if (we === 1'b1) begin
        nwe++;
        psum += int'(pixel_in);
      end
      if (i == 4) begin
        u_bus.cs      = 1'b1;
        u_bus.write   = 1'b1;
        u_bus.addr    = REG_BMP_DATA;
        u_bus.wr_data = 32'hFFFF_FFFF;
      end
      if (i == 5) begin
        u_bus.cs    = 1'b0;
        u_bus.write = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (nwe != 16)
      $display("FAIL ovf_wecount: got %0d want 16", nwe);
    else passed++;
    total++;
    if (psum != 0)
      $display("FAIL ovf_pixsum: got %0d want 0", psum);
    else passed++;
    rd(REG_STATUS, d);
    total++;
    if (d !== 32'h0074_0002)
      $display("FAIL ovf_status: got %h want 00740002", d);
    else passed++;
    wr(REG_STATUS, 32'h0);
    rd(REG_STATUS, d);
    total++;
    if (d !== 32'h0074_0000)
      $display("FAIL ovf_clear: got %h want 00740000", d);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(REG_BMP_ADDR, 32'd200);
    wr(REG_BMP_DATA, 32'h0000_0000);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (we !== 1'b1 || addr_w !== 10'd215)
      $display("FAIL b2b_last: got we=%b a=%0d want 1 215",
               we, addr_w);
    else passed++;
    wr(REG_BMP_DATA, 32'h0000_0003);
    total++;
    if (we !== 1'b1 || addr_w !== 10'd216 ||
        pixel_in !== 2'd3)
      $display("FAIL b2b_next: got we=%b a=%0d p=%0d want 1 216 3",
               we, addr_w, pixel_in);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
    end
    rd(REG_STATUS, d);
    total++;
    if (d !== 32'h00E8_0000)
      $display("FAIL b2b_status: got %h want 00e80000", d);
    else passed++;
  endtask

  task automatic test_pos();
    logic [31:0] d;
    wr(REG_POS, {5'd0, 11'd200, 5'd0, 11'd100});
    total++;
    if (x0 !== 11'd0 || y0 !== 11'd400)
      $display("FAIL pos_hold: got %0d,%0d want 0,400", x0, y0);
    else passed++;
    rd(REG_STATUS, d);
    total++;
    if (d[2] !== 1'b1)
      $display("FAIL pos_pend1: got %b want 1", d[2]);
    else passed++;
    rd(REG_POS, d);
    total++;
    if (d !== 32'h00C8_0064)
      $display("FAIL pos_readback: got %h want 00c80064", d);
    else passed++;
    fs_pulse();
    total++;
    if (x0 !== 11'd100 || y0 !== 11'd200)
      $display("FAIL pos_commit: got %0d,%0d want 100,200",
               x0, y0);
    else passed++;
    rd(REG_STATUS, d);
    total++;
    if (d[2] !== 1'b0)
      $display("FAIL pos_pend0: got %b want 0", d[2]);
    else passed++;
    fs_pulse();
    total++;
    if (x0 !== 11'd100 || y0 !== 11'd200)
      $display("FAIL pos_idle_fs: got %0d,%0d want 100,200",
               x0, y0);
    else passed++;
    @(negedge clk);
    u_bus.cs      = 1'b1;
    u_bus.write   = 1'b1;
    u_bus.addr    = REG_POS;
    u_bus.wr_data = {5'd0, 11'd50, 5'd0, 11'd300};
    frame_start   = 1'b1;
    @(posedge clk);
    #1;
    u_bus.cs    = 1'b0;
    u_bus.write = 1'b0;
    frame_start = 1'b0;
    total++;
    if (x0 !== 11'd300 || y0 !== 11'd50)
      $display("FAIL pos_same_cycle: got %0d,%0d want 300,50",
               x0, y0);
    else passed++;
    rd(REG_STATUS, d);
    total++;
    if (d[2] !== 1'b0)
      $display("FAIL pos_same_pend: got %b want 0", d[2]);
    else passed++;
    wr(REG_POS, {5'd0, 11'd2, 5'd0, 11'd1});
    wr(REG_POS, {5'd0, 11'd4, 5'd0, 11'd3});
    fs_pulse();
    total++;
    if (x0 !== 11'd3 || y0 !== 11'd4)
      $display("FAIL pos_last_wins: got %0d,%0d want 3,4",
               x0, y0);
    else passed++;
  endtask

  task automatic test_enable();
    logic [31:0] d;
    wr(REG_CTRL, 32'd0);
    total++;
    if (x0 !== 11'd2047 || y0 !== 11'd4)
      $display("FAIL en_off: got %0d,%0d want 2047,4", x0, y0);
    else passed++;
    rd(REG_CTRL, d);
    total++;
    if (d !== 32'd0)
      $display("FAIL en_rd0: got %h want 0", d);
    else passed++;
    wr(REG_CTRL, 32'd1);
    total++;
    if (x0 !== 11'd3)
      $display("FAIL en_on: got %0d want 3", x0);
    else passed++;
    rd(REG_CTRL, d);
    total++;
    if (d !== 32'd1)
      $display("FAIL en_rd1: got %h want 1", d);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(REG_BMP_ADDR, 32'd0);
    wr(REG_BMP_DATA, 32'hFFFF_FFFF);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (we !== 1'b1 || addr_w !== 10'd7)
      $display("FAIL rst_pre: got we=%b a=%0d want 1 7",
               we, addr_w);
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (we !== 1'b0)
      $display("FAIL rst_we_async: got %b want 0", we);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (we !== 1'b0)
      $display("FAIL rst_no_resume: got %b want 0", we);
    else passed++;
    rd(REG_STATUS, d);
    total++;
    if (d !== 32'h0)
      $display("FAIL rst_status: got %h want 0", d);
    else passed++;
    total++;
    if (x0 !== 11'd0 || y0 !== 11'd400)
      $display("FAIL rst_pos: got %0d,%0d want 0,400", x0, y0);
    else passed++;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    rst_n         = 1'b0;
    frame_start   = 1'b0;
    u_bus.cs      = 1'b0;
    u_bus.write   = 1'b0;
    u_bus.read    = 1'b0;
    u_bus.addr    = '0;
    u_bus.wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_wrap();
    test_ovf();
    test_back_to_back();
    test_pos();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
